// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer
//   Top-level phase controller for the multicycle core. It steps the pipeline
//   through FETCH -> DECODE -> EXEC -> [MEM] -> WRITE and handshakes with the
//   variable-latency resources (instruction memory, FPU, data memory, UART).
//   It also raises a one-cycle commit strobe per retired instruction and parks
//   in WRITE when a halt is requested.
//
// Parameters
//   FPU_TIMEOUT : EXEC cycles to wait on fpu_done before aborting (1..255)
//   CNT_W       : width of the optional performance counters
//
// Ports
//   clk, rst          : clock, asynchronous active-low reset
//   halt_req          : stop after the current instruction commits
//   imem_ready        : instruction word valid
//   dec_*             : decoded instruction class, stable from EXEC onwards
//   fpu_done          : FPU result valid
//   mem_ready         : data memory access complete
//   rx_valid/tx_ready : UART handshakes
//   state             : current phase (FETCH=0 DECODE=1 EXEC=2 MEM=3 WRITE=4)
//   fetch_req         : instruction fetch request (level)
//   fpu_start         : one-cycle FPU launch pulse
//   mem_req           : data memory request (level)
//   rx_ack            : one-cycle rx consume pulse
//   tx_valid          : tx data valid (level)
//   commit            : one-cycle pc/regfile write enable
//   halted, fpu_err   : sticky status flags
//
// Build option
//   SEQ_PERF_CNT_EN : adds cycle_cnt, instret_cnt and stall_cnt outputs.

module multicycle_sequencer #(
    parameter int unsigned FPU_TIMEOUT = 64,
    parameter int unsigned CNT_W       = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       halt_req,
    input  logic       imem_ready,
    input  logic       dec_use_fpu,
    input  logic       dec_mem_read,
    input  logic       dec_mem_write,
    input  logic       dec_data_in,
    input  logic       dec_data_out,
    input  logic       fpu_done,
    input  logic       mem_ready,
    input  logic       rx_valid,
    input  logic       tx_ready,
    output logic [2:0] state,
    output logic       fetch_req,
    output logic       fpu_start,
    output logic       mem_req,
    output logic       rx_ack,
    output logic       tx_valid,
    output logic       commit,
    output logic       halted,
    output logic       fpu_err
`ifdef SEQ_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt,
    output logic [CNT_W-1:0] stall_cnt
`endif
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WRITE  = 3'd4
    } state_e;

    localparam logic [7:0] TMO_LIMIT = 8'(FPU_TIMEOUT);

    if (FPU_TIMEOUT < 1 || FPU_TIMEOUT > 255 || CNT_W < 1) begin : g_param_check
        $error("multicycle_sequencer: FPU_TIMEOUT must be 1..255 and CNT_W >= 1");
    end

    state_e     state_q, state_d;
    logic [7:0] tmo_cnt_q, tmo_cnt_d;
    logic       stay_q;               // 1 when the current phase is past its first cycle
    logic       halted_q, halted_d;
    logic       fpu_err_q, fpu_err_d;
    logic       abort_q, abort_d;     // current WRITE follows an FPU timeout
    logic       exec_done;

    // Handshake outputs depend on same-cycle inputs (rx_ack, exit on tx_ready)
    // and on dec_* which only become valid in EXEC, so they are decoded here
    // from the registered phase rather than pre-registered a cycle early.
    always_comb begin
        state_d   = state_q;
        tmo_cnt_d = '0;
        halted_d  = halted_q;
        fpu_err_d = fpu_err_q;
        abort_d   = abort_q;
        exec_done = 1'b0;
        fetch_req = 1'b0;
        fpu_start = 1'b0;
        mem_req   = 1'b0;
        rx_ack    = 1'b0;
        tx_valid  = 1'b0;
        commit    = 1'b0;

        case (state_q)
            FETCH: begin
                // Reset value of the phase is FETCH; keep the request low
                // while reset is held.
                fetch_req = rst;
                if (imem_ready) begin
                    state_d = DECODE;
                end
            end

            DECODE: begin
                state_d = EXEC;
            end

            EXEC: begin
                if (dec_use_fpu) begin
                    fpu_start = !stay_q;
                    // fpu_done coincident with the launch pulse is stale.
                    if (stay_q && fpu_done) begin
                        exec_done = 1'b1;
                    end else if (tmo_cnt_q + 8'd1 == TMO_LIMIT) begin
                        fpu_err_d = 1'b1;
                        abort_d   = 1'b1;
                        state_d   = WRITE;
                    end else begin
                        tmo_cnt_d = tmo_cnt_q + 8'd1;
                    end
                end else if (dec_data_in) begin
                    rx_ack    = rx_valid;
                    exec_done = rx_valid;
                end else if (dec_data_out) begin
                    tx_valid  = 1'b1;
                    exec_done = tx_ready;
                end else begin
                    exec_done = 1'b1;
                end

                if (exec_done) begin
                    state_d = (dec_mem_read || dec_mem_write) ? MEM : WRITE;
                end
            end

            MEM: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    state_d = WRITE;
                end
            end

            WRITE: begin
                if (!halted_q) begin
                    commit  = !abort_q;
                    abort_d = 1'b0;
                    if (halt_req) begin
                        halted_d = 1'b1;
                    end else begin
                        state_d = FETCH;
                    end
                end
            end

            default: begin
                state_d = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= FETCH;
            tmo_cnt_q <= '0;
            stay_q    <= 1'b0;
            halted_q  <= 1'b0;
            fpu_err_q <= 1'b0;
            abort_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            tmo_cnt_q <= tmo_cnt_d;
            stay_q    <= (state_d == state_q);
            halted_q  <= halted_d;
            fpu_err_q <= fpu_err_d;
            abort_q   <= abort_d;
        end
    end

    assign state   = state_q;
    assign halted  = halted_q;
    assign fpu_err = fpu_err_q;

`ifdef SEQ_PERF_CNT_EN
    logic [CNT_W-1:0] cycle_cnt_q, instret_cnt_q, stall_cnt_q;
    logic             stall;

    assign stall = stay_q && (state_q == FETCH || state_q == EXEC || state_q == MEM);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycle_cnt_q   <= '0;
            instret_cnt_q <= '0;
            stall_cnt_q   <= '0;
        end else begin
            if (!halted_q) begin
                cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);
            end
            if (commit) begin
                instret_cnt_q <= instret_cnt_q + CNT_W'(1);
            end
            if (stall) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
        end
    end

    assign cycle_cnt   = cycle_cnt_q;
    assign instret_cnt = instret_cnt_q;
    assign stall_cnt   = stall_cnt_q;
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Bench for multicycle_sequencer. Two instances share all inputs: dut uses the
// default FPU_TIMEOUT, dut_t uses FPU_TIMEOUT=4 for the abort scenario.
// Input vector bits  : {halt,imem | fpu,rd,wr | din,dout | fdone,mrdy,rxv,txr}
// Output vector bits : {state[2:0] | fetch_req,fpu_start,mem_req |
//                       rx_ack,tx_valid,commit | halted,fpu_err}

module tb_multicycle_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic halt_req, imem_ready, dec_use_fpu, dec_mem_read, dec_mem_write;
    logic dec_data_in, dec_data_out, fpu_done, mem_ready, rx_valid, tx_ready;

    logic [2:0] st_a, st_b;
    logic fr_a, fs_a, mr_a, ra_a, tv_a, cm_a, hl_a, er_a;
    logic fr_b, fs_b, mr_b, ra_b, tv_b, cm_b, hl_b, er_b;

    always #5 clk = ~clk;

    multicycle_sequencer #(.FPU_TIMEOUT(64), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .halt_req(halt_req), .imem_ready(imem_ready),
        .dec_use_fpu(dec_use_fpu), .dec_mem_read(dec_mem_read),
        .dec_mem_write(dec_mem_write), .dec_data_in(dec_data_in),
        .dec_data_out(dec_data_out), .fpu_done(fpu_done), .mem_ready(mem_ready),
        .rx_valid(rx_valid), .tx_ready(tx_ready), .state(st_a),
        .fetch_req(fr_a), .fpu_start(fs_a), .mem_req(mr_a), .rx_ack(ra_a),
        .tx_valid(tv_a), .commit(cm_a), .halted(hl_a), .fpu_err(er_a)
    );

    multicycle_sequencer #(.FPU_TIMEOUT(4), .CNT_W(32)) dut_t (
        .clk(clk), .rst(rst), .halt_req(halt_req), .imem_ready(imem_ready),
        .dec_use_fpu(dec_use_fpu), .dec_mem_read(dec_mem_read),
        .dec_mem_write(dec_mem_write), .dec_data_in(dec_data_in),
        .dec_data_out(dec_data_out), .fpu_done(fpu_done), .mem_ready(mem_ready),
        .rx_valid(rx_valid), .tx_ready(tx_ready), .state(st_b),
        .fetch_req(fr_b), .fpu_start(fs_b), .mem_req(mr_b), .rx_ack(ra_b),
        .tx_valid(tv_b), .commit(cm_b), .halted(hl_b), .fpu_err(er_b)
    );

    typedef struct {
        string       nm;
        bit          do_rst;
        logic [10:0] in;
        logic [10:0] ex;
    } vec_t;

    typedef struct {
        string       nm;
        logic [10:0] ex;
        bit          use_t;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    function automatic logic [10:0] act(input bit t);
        if (t) return {st_b, fr_b, fs_b, mr_b, ra_b, tv_b, cm_b, hl_b, er_b};
        return {st_a, fr_a, fs_a, mr_a, ra_a, tv_a, cm_a, hl_a, er_a};
    endfunction

    function automatic void add(input string nm, input bit r,
                                input logic [10:0] in, input logic [10:0] ex);
        vecs.push_back('{nm, r, in, ex});
    endfunction

    task automatic check(input string nm, input logic [10:0] got, input logic [10:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", nm, got, exp);
        end
    endtask

    task automatic drive(input logic [10:0] in);
        {halt_req, imem_ready, dec_use_fpu, dec_mem_read, dec_mem_write,
         dec_data_in, dec_data_out, fpu_done, mem_ready, rx_valid, tx_ready} = in;
    endtask

    // One cycle: drive at posedge+1, compare at the following negedge.
    task automatic step(input string nm, input logic [10:0] in,
                        input logic [10:0] ex, input bit t);
        exp_t e;
        drive(in);
        sb.push_back('{nm, ex, t});
        @(negedge clk);
        e = sb.pop_front();
        check(e.nm, act(e.use_t), e.ex);
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench at posedge+1 of the first cycle after release.
    task automatic apply_reset();
        exp_t e;
        rst = 1'b0;
        drive('0);
        @(posedge clk);
        #1;
        sb.push_back('{"reset dut", 11'b000_000_000_00, 1'b0});
        sb.push_back('{"reset dut_t", 11'b000_000_000_00, 1'b1});
        @(negedge clk);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.nm, act(e.use_t), e.ex);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int guard;

        // Plain ALU op, handshakes ready: 0,1,2,4,0 with commit at cycle 3.
        add("plain c0", 1, 11'b01_000_00_0100, 11'b000_100_000_00);
        add("plain c1", 0, 11'b01_000_00_0100, 11'b001_000_000_00);
        add("plain c2", 0, 11'b01_000_00_0100, 11'b010_000_000_00);
        add("plain c3", 0, 11'b01_000_00_0100, 11'b100_000_001_00);
        add("plain c4", 0, 11'b01_000_00_0100, 11'b000_100_000_00);
        // FPU: done with the launch pulse is ignored, done 5 cycles later ends EXEC.
        add("fpu c0", 1, 11'b01_100_00_0000, 11'b000_100_000_00);
        add("fpu c1", 0, 11'b01_100_00_0000, 11'b001_000_000_00);
        add("fpu c2", 0, 11'b01_100_00_1000, 11'b010_010_000_00);
        add("fpu c3", 0, 11'b01_100_00_0000, 11'b010_000_000_00);
        add("fpu c4", 0, 11'b01_100_00_0000, 11'b010_000_000_00);
        add("fpu c5", 0, 11'b01_100_00_0000, 11'b010_000_000_00);
        add("fpu c6", 0, 11'b01_100_00_0000, 11'b010_000_000_00);
        add("fpu c7", 0, 11'b01_100_00_1000, 11'b010_000_000_00);
        add("fpu c8", 0, 11'b01_100_00_0010, 11'b100_000_001_00);
        add("fpu c9", 0, 11'b01_100_00_0000, 11'b000_100_000_00);
        // Load: one FETCH stall, mem_ready after 3 cycles -> mem_req for 4.
        add("load c0", 1, 11'b00_010_00_0000, 11'b000_100_000_00);
        add("load c1", 0, 11'b01_010_00_0000, 11'b000_100_000_00);
        add("load c2", 0, 11'b01_010_00_0000, 11'b001_000_000_00);
        add("load c3", 0, 11'b01_010_00_0000, 11'b010_000_000_00);
        add("load c4", 0, 11'b01_010_00_0000, 11'b011_001_000_00);
        add("load c5", 0, 11'b01_010_00_0000, 11'b011_001_000_00);
        add("load c6", 0, 11'b01_010_00_0000, 11'b011_001_000_00);
        add("load c7", 0, 11'b01_010_00_0100, 11'b011_001_000_00);
        add("load c8", 0, 11'b01_010_00_0000, 11'b100_000_001_00);
        add("load c9", 0, 11'b01_010_00_0000, 11'b000_100_000_00);
        // Store with mem_ready on entry: single MEM cycle.
        add("store c0", 1, 11'b01_001_00_0100, 11'b000_100_000_00);
        add("store c1", 0, 11'b01_001_00_0100, 11'b001_000_000_00);
        add("store c2", 0, 11'b01_001_00_0100, 11'b010_000_000_00);
        add("store c3", 0, 11'b01_001_00_0100, 11'b011_001_000_00);
        add("store c4", 0, 11'b01_001_00_0100, 11'b100_000_001_00);
        add("store c5", 0, 11'b01_001_00_0100, 11'b000_100_000_00);
        // UART in: rx_valid after 2 waiting cycles, one rx_ack pulse.
        add("din c0", 1, 11'b01_000_10_0000, 11'b000_100_000_00);
        add("din c1", 0, 11'b01_000_10_0000, 11'b001_000_000_00);
        add("din c2", 0, 11'b01_000_10_0000, 11'b010_000_000_00);
        add("din c3", 0, 11'b01_000_10_0000, 11'b010_000_000_00);
        add("din c4", 0, 11'b01_000_10_0010, 11'b010_000_100_00);
        add("din c5", 0, 11'b01_000_10_0010, 11'b100_000_001_00);
        add("din c6", 0, 11'b01_000_10_0010, 11'b000_100_000_00);
        // UART out: tx_ready after 3 cycles, tx_valid high for 4.
        add("dout c0", 1, 11'b01_000_01_0000, 11'b000_100_000_00);
        add("dout c1", 0, 11'b01_000_01_0000, 11'b001_000_000_00);
        add("dout c2", 0, 11'b01_000_01_0000, 11'b010_000_010_00);
        add("dout c3", 0, 11'b01_000_01_0000, 11'b010_000_010_00);
        add("dout c4", 0, 11'b01_000_01_0000, 11'b010_000_010_00);
        add("dout c5", 0, 11'b01_000_01_0001, 11'b010_000_010_00);
        add("dout c6", 0, 11'b01_000_01_0001, 11'b100_000_001_00);
        add("dout c7", 0, 11'b01_000_01_0001, 11'b000_100_000_00);
        // UART out + store, both ready at once: 1-cycle EXEC then 1-cycle MEM.
        add("doutst c0", 1, 11'b01_001_01_0101, 11'b000_100_000_00);
        add("doutst c1", 0, 11'b01_001_01_0101, 11'b001_000_000_00);
        add("doutst c2", 0, 11'b01_001_01_0101, 11'b010_000_010_00);
        add("doutst c3", 0, 11'b01_001_01_0101, 11'b011_001_000_00);
        add("doutst c4", 0, 11'b01_001_01_0101, 11'b100_000_001_00);
        // FPU beats data_in: rx_valid present but never acknowledged.
        add("prio c0", 1, 11'b01_100_10_0010, 11'b000_100_000_00);
        add("prio c1", 0, 11'b01_100_10_0010, 11'b001_000_000_00);
        add("prio c2", 0, 11'b01_100_10_0010, 11'b010_010_000_00);
        add("prio c3", 0, 11'b01_100_10_1010, 11'b010_000_000_00);
        add("prio c4", 0, 11'b01_100_10_0010, 11'b100_000_001_00);
        // Halt pulsed in DECODE, then held from WRITE: one commit, then parked.
        add("halt c0", 1, 11'b01_000_00_0000, 11'b000_100_000_00);
        add("halt c1", 0, 11'b11_000_00_0000, 11'b001_000_000_00);
        add("halt c2", 0, 11'b01_000_00_0000, 11'b010_000_000_00);
        add("halt c3", 0, 11'b11_000_00_0000, 11'b100_000_001_00);
        add("halt c4", 0, 11'b11_000_00_0000, 11'b100_000_000_10);
        add("halt c5", 0, 11'b01_000_00_0000, 11'b100_000_000_10);
        add("halt c6", 0, 11'b01_000_00_0000, 11'b100_000_000_10);

        drive('0);
        foreach (vecs[i]) begin
            if (vecs[i].do_rst) apply_reset();
            step(vecs[i].nm, vecs[i].in, vecs[i].ex, 1'b0);
        end

        // FPU timeout on dut_t (limit 4): a load that aborts straight to WRITE.
        apply_reset();
        drive(11'b01_110_00_0000);
        n = 0;
        guard = 0;
        while (st_b != 3'd2 && guard < 20) begin
            @(posedge clk);
            #1;
            guard++;
        end
        while (st_b == 3'd2 && guard < 20) begin
            n++;
            @(posedge clk);
            #1;
            guard++;
        end
        check("tmo bounded wait", 11'(guard < 20), 11'd1);
        check("tmo exec cycles", 11'(n), 11'd4);
        step("tmo write", 11'b01_110_00_0000, 11'b100_000_000_01, 1'b1);
        step("tmo fetch", 11'b01_000_00_0100, 11'b000_100_000_01, 1'b1);
        step("tmo nxt c1", 11'b01_000_00_0100, 11'b001_000_000_01, 1'b1);
        step("tmo nxt c2", 11'b01_000_00_0100, 11'b010_000_000_01, 1'b1);
        step("tmo nxt c3", 11'b01_000_00_0100, 11'b100_000_001_01, 1'b1);
        step("tmo nxt c4", 11'b01_000_00_0100, 11'b000_100_000_01, 1'b1);

        // Reset asserted mid-MEM takes effect without waiting for a clock.
        apply_reset();
        step("rstmem c0", 11'b01_010_00_0000, 11'b000_100_000_00, 1'b0);
        step("rstmem c1", 11'b01_010_00_0000, 11'b001_000_000_00, 1'b0);
        step("rstmem c2", 11'b01_010_00_0000, 11'b010_000_000_00, 1'b0);
        step("rstmem c3", 11'b01_010_00_0000, 11'b011_001_000_00, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        check("rstmem async dut", act(1'b0), 11'b000_000_000_00);
        check("rstmem async dut_t", act(1'b1), 11'b000_000_000_00);
        @(negedge clk);
        check("rstmem held", act(1'b0), 11'b000_000_000_00);
        @(posedge clk);
        #1;
        rst = 1'b1;
        step("rstmem rel c0", 11'b01_010_00_0000, 11'b000_100_000_00, 1'b0);
        step("rstmem rel c1", 11'b01_010_00_0000, 11'b001_000_000_00, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
- Top-level state controller for the multicycle core. Drives the 3-bit pipeline `state` (FETCH=0, DECODE=1, EXEC=2, MEM=3, WRITE=4) consumed by decode, ALU, FPU, memory and writeback logic.
- Handshakes with variable-latency resources: instruction memory, FPU, data memory, UART rx/tx.
- Emits single-cycle commit strobes and halts cleanly on request.

Parameters:
- FPU_TIMEOUT, 64, max EXEC cycles waiting on fpu_done before error abort (8-bit counter; legal range 1..255).
- CNT_W, 32, width of optional performance counters.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- halt_req  in  1  request stop after the current instruction commits
- imem_ready  in  1  instruction word valid this cycle
- dec_use_fpu  in  1  decoded: instruction uses FPU
- dec_mem_read  in  1  decoded: load
- dec_mem_write  in  1  decoded: store
- dec_data_in  in  1  decoded: UART input instruction
- dec_data_out  in  1  decoded: UART output instruction
- fpu_done  in  1  FPU result valid
- mem_ready  in  1  data memory access complete
- rx_valid  in  1  UART rx byte available
- tx_ready  in  1  UART tx can accept
- state  out  3  current phase
- fetch_req  out  1  instruction fetch request
- fpu_start  out  1  one-cycle FPU launch pulse
- mem_req  out  1  data memory request (level)
- rx_ack  out  1  one-cycle rx consume pulse
- tx_valid  out  1  tx data valid (level)
- commit  out  1  one-cycle pc/regfile write enable
- halted  out  1  sticky halted flag
- fpu_err  out  1  sticky FPU timeout flag

Behaviour:
- Reset (rst=0, asynchronous): state=FETCH. All strobes and levels 0. halted=0, fpu_err=0, timeout counter 0, sub-phase flags cleared. The first cycle after release is FETCH.
- Reset asserted mid-operation: abandon any outstanding handshake immediately. No commit is issued.
- FETCH:
  - fetch_req=1.
  - When imem_ready=1, go to DECODE next cycle; otherwise stay.
- DECODE:
  - Exactly 1 cycle, then EXEC.
  - dec_* inputs are registered by the decoder at the end of DECODE. The sequencer samples them only in EXEC/MEM.
- EXEC, evaluated in priority order: fpu > data_in > data_out > plain.
  - Plain: 1 cycle.
  - FPU:
    - fpu_start=1 on the first EXEC cycle only.
    - fpu_done is ignored in that cycle. From the next cycle, fpu_done=1 ends EXEC.
    - Timeout counter increments each waiting cycle. On reaching FPU_TIMEOUT without done: fpu_err<=1, go to WRITE with commit suppressed.
  - data_in: wait for rx_valid. In the cycle rx_valid=1, rx_ack=1 and EXEC ends.
  - data_out:
    - tx_valid=1 from the first EXEC cycle until tx_ready=1, inclusive of that cycle.
    - tx_valid drops the following cycle.
    - tx_ready already high on the first cycle gives a 1-cycle EXEC.
  - Exit: if dec_mem_read|dec_mem_write go to MEM, else go to WRITE.
- MEM:
  - mem_req=1 until mem_ready=1, inclusive of that cycle. Then go to WRITE.
  - mem_ready high on entry gives a 1-cycle MEM.
  - Read and write both set is illegal; behaves as a single access.
- WRITE:
  - commit=1 for exactly 1 cycle, except after an FPU timeout.
  - If halt_req=1 during WRITE: halted<=1, state stays at WRITE with commit=0 until reset. Otherwise go to FETCH.
- halt_req outside WRITE has no effect until WRITE is reached.
- Minimum instruction latency: 4 cycles (FETCH, DECODE, EXEC, WRITE), with all handshakes ready immediately.
- Stray handshake inputs in the wrong phase are ignored.

Optional Feature:
- Macro SEQ_PERF_CNT_EN.
- Defined: adds outputs cycle_cnt[CNT_W], instret_cnt[CNT_W], stall_cnt[CNT_W]. All three reset to 0 and wrap modulo 2^CNT_W.
  - cycle_cnt: +1 every cycle while not halted.
  - instret_cnt: +1 per commit.
  - stall_cnt: +1 per cycle spent waiting in FETCH, EXEC or MEM beyond that phase's first cycle.
- Undefined: these ports and registers are absent; all other behaviour is identical.

Test Plan:
- Plain ALU op, imem_ready/mem_ready tied high: state sequence 0,1,2,4,0. commit high exactly at cycle 3 after reset release.
- FPU op, fpu_done raised 5 cycles after fpu_start: fpu_start is one pulse; EXEC lasts 6 cycles; then WRITE with commit=1. Also drive fpu_done=1 coincident with fpu_start: it must be ignored.
- FPU op, FPU_TIMEOUT=4, fpu_done never asserted: fpu_err=1 after 4 waiting cycles; WRITE reached with commit=0; next state FETCH.
- Load with mem_ready delayed 3 cycles: mem_req high for 4 cycles, then WRITE and commit. Store with mem_ready high on entry: MEM lasts 1 cycle.
- UART: data_in with rx_valid after 2 cycles gives a single rx_ack pulse. data_out with tx_ready after 3 cycles keeps tx_valid high for 4 cycles.
- halt_req pulsed in DECODE then held through WRITE: commit once, halted=1, no further fetch_req. rst low mid-MEM: state=0 and mem_req=0 asynchronously.
